// File: rtl/operand_sequencer_pkg.sv
// ============================================================================
// Package     : opseq_pkg
// Description : Shared state encoding, B-operand shift codes and default
//               widths for the operand sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package opseq_pkg;

  // Datapath width matches the 8x16 register file; 3 select bits give 8 regs.
  localparam int OPSEQ_W    = 16;
  localparam int OPSEQ_RSEL = 3;

  // One state per register-file / ALU phase of a command.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } opseq_state_t;

  // B-operand shift codes.
  localparam logic [1:0] SH_NONE = 2'b00;  // pass through
  localparam logic [1:0] SH_LSL  = 2'b01;  // shift left 1, lsb 0
  localparam logic [1:0] SH_LSR  = 2'b10;  // logical shift right 1, msb 0
  localparam logic [1:0] SH_ASR  = 2'b11;  // arithmetic shift right 1

endpackage

`default_nettype wire

// File: rtl/operand_sequencer_if.sv
// ============================================================================
// Interface   : operand_sequencer_if
// Description : Command, register-file and ALU signals of the operand
//               sequencer. master = the sequencer; slave = command source,
//               register file and ALU around it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_sequencer_if
  import opseq_pkg::*;
#(
  parameter int W    = OPSEQ_W,
  parameter int RSEL = OPSEQ_RSEL
);

  // Command side
  logic            start;
  logic [RSEL-1:0] rn;
  logic [RSEL-1:0] rm;
  logic [RSEL-1:0] rd;
  logic            one_op;
  logic            wb_en;
  logic [1:0]      shift;
  logic            busy;
  logic            done;

  // Register file / ALU side
  logic [W-1:0]    rf_rdata;
  logic [W-1:0]    alu_res;
  logic [RSEL-1:0] readnum;
  logic [RSEL-1:0] writenum;
  logic            write;
  logic [W-1:0]    data_in;
  logic [W-1:0]    a_out;
  logic [W-1:0]    b_out;

  modport master (
    input  start, rn, rm, rd, one_op, wb_en, shift, rf_rdata, alu_res,
    output readnum, writenum, write, data_in, a_out, b_out, busy, done
  );

  modport slave (
    output start, rn, rm, rd, one_op, wb_en, shift, rf_rdata, alu_res,
    input  readnum, writenum, write, data_in, a_out, b_out, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/operand_sequencer_shifter.sv
// ============================================================================
// Module      : opseq_shifter
// Description : Combinational W-bit single-position shifter applied to the B
//               operand as it is loaded. Only instanced when OPSEQ_SHIFT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opseq_shifter
  import opseq_pkg::*;
#(
  parameter int W = OPSEQ_W
) (
  input  wire logic [W-1:0] din,
  input  wire logic [1:0]   code,
  output logic      [W-1:0] dout
);

  // Select the shifted form of din according to the shift code.
  always_comb begin
    dout = din;
    case (code)
      SH_LSL:  dout = {din[W-2:0], 1'b0};
      SH_LSR:  dout = {1'b0, din[W-1:1]};
      SH_ASR:  dout = {din[W-1], din[W-1:1]};
      default: dout = din;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/operand_sequencer.sv
// ============================================================================
// Module      : operand_sequencer
// Description : Multi-cycle controller in front of the register file. Per
//               accepted command it reads A and B through the single read
//               port, captures the external ALU result into C and writes C
//               back to rd. Outputs are decoded from state and latched
//               fields only.
//               Optional feature macro: OPSEQ_SHIFT_EN (shift B on load).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int W    = OPSEQ_W,
  parameter int RSEL = OPSEQ_RSEL
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  operand_sequencer_if.master  bus
);

  opseq_state_t    r_state;
  opseq_state_t    w_state_nxt;

  logic [RSEL-1:0] r_rn;
  logic [RSEL-1:0] r_rm;
  logic [RSEL-1:0] r_rd;
  logic            r_wb_en;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_c;
  logic [W-1:0]    w_b_load;
  logic            w_accept;

  // A command is taken only while idle; starts in any other state are dropped.
  assign w_accept = (r_state == S_IDLE) && bus.start;

`ifdef OPSEQ_SHIFT_EN
  logic [1:0] r_shift;

  opseq_shifter #(.W(W)) u_shifter (
    .din  (bus.rf_rdata),
    .code (r_shift),
    .dout (w_b_load)
  );
`else
  logic w_unused_shift;

  assign w_b_load       = bus.rf_rdata;
  assign w_unused_shift = ^bus.shift;
`endif

  // State register; reset returns to IDLE immediately, dropping write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_state_nxt  = r_state;
    bus.readnum  = r_rn;
    bus.writenum = r_rd;
    bus.write    = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = bus.one_op ? S_RD_B : S_RD_A;
        end
      end
      S_RD_A: begin
        w_state_nxt = S_RD_B;
      end
      S_RD_B: begin
        bus.readnum = r_rm;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_WB;
      end
      S_WB: begin
        bus.write   = r_wb_en;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch command fields on accept and load A/B/C in their phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rn    <= '0;
      r_rm    <= '0;
      r_rd    <= '0;
      r_wb_en <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
`ifdef OPSEQ_SHIFT_EN
      r_shift <= SH_NONE;
`endif
    end else begin
      if (w_accept) begin
        r_rn    <= bus.rn;
        r_rm    <= bus.rm;
        r_rd    <= bus.rd;
        r_wb_en <= bus.wb_en;
`ifdef OPSEQ_SHIFT_EN
        r_shift <= bus.shift;
`endif
        // Single-operand commands skip the A read, so A is cleared here.
        if (bus.one_op) begin
          r_a <= '0;
        end
      end
      case (r_state)
        S_RD_A:  r_a <= bus.rf_rdata;
        S_RD_B:  r_b <= w_b_load;
        S_EXEC:  r_c <= bus.alu_res;
        default: ;
      endcase
    end
  end

  assign bus.data_in = r_c;
  assign bus.a_out   = r_a;
  assign bus.b_out   = r_b;

endmodule

`default_nettype wire

// File: tb/tb_operand_sequencer.sv
// ============================================================================
// Module      : tb_operand_sequencer
// Description : Self-checking bench: operand_sequencer with an 8x16 register
//               file and adder ALU, scoreboard of expected command results.
//               Honours OPSEQ_SHIFT_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_operand_sequencer;
  import opseq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  operand_sequencer_if #(.W(16), .RSEL(3)) bus ();

  operand_sequencer #(.W(16), .RSEL(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file (combinational read, clocked write) plus a backdoor port
  logic [7:0][15:0] rf_mem;
  logic             bd_we;
  logic [2:0]       bd_addr;
  logic [15:0]      bd_data;

  always @(posedge clk) begin
    if (bd_we) rf_mem[bd_addr] <= bd_data;
    else if (bus.write) rf_mem[bus.writenum] <= bus.data_in;
  end

  assign bus.rf_rdata = rf_mem[bus.readnum];
  assign bus.alu_res  = bus.a_out + bus.b_out;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               acc;
    int               lat;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [15:0]      c;
    logic [7:0][15:0] img;
    int               wr;
  } exp_t;

  exp_t             sbq[$];
  logic [7:0][15:0] ref_rf;
  int n_vec    = 0;
  int n_err    = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen, none allowed", nm);
  endtask

  // Reference for the B operand transform.
  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
`ifdef OPSEQ_SHIFT_EN
    case (s)
      2'd1:    return 16'(v * 16'd2);
      2'd2:    return v / 16'd2;
      2'd3:    return 16'($signed(v) >>> 1);
      default: return v;
    endcase
`else
    return (s == 2'd0) ? v : v;
`endif
  endfunction

  // Monitor: on every done pulse compare against the oldest expectation.
  initial begin
    exp_t me;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_cnt = 0;
      end else begin
        if (bus.write === 1'b1) wr_cnt++;
        if (bus.done === 1'b1) begin
          done_cnt++;
          if (sbq.size() == 0) begin
            flag("spurious_done");
          end else begin
            me = sbq.pop_front();
            chk("latency", 128'(cyc - me.acc + 1), 128'(me.lat));
            chk("a_out", bus.a_out, me.a);
            chk("b_out", bus.b_out, me.b);
            chk("data_in", bus.data_in, me.c);
            chk("rf_image", rf_mem, me.img);
            chk("write_pulses", 128'(wr_cnt), 128'(me.wr));
          end
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) flag("idle_timeout");
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    wait_idle();
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_rf[a] = d;
  endtask

  task automatic scramble();
    bus.rn     = 3'($urandom_range(0, 7));
    bus.rm     = 3'($urandom_range(0, 7));
    bus.rd     = 3'($urandom_range(0, 7));
    bus.one_op = 1'($urandom_range(0, 1));
    bus.wb_en  = 1'($urandom_range(0, 1));
    bus.shift  = 2'($urandom_range(0, 3));
  endtask

  // Expected outcome of one command applied to the reference register file.
  task automatic model(input int acc, input logic [2:0] rn, input logic [2:0] rm,
                       input logic [2:0] rd, input logic oo, input logic wb,
                       input logic [1:0] sh);
    exp_t e;
    e.acc = acc;
    e.lat = oo ? 4 : 5;
    e.a   = oo ? 16'h0 : ref_rf[rn];
    e.b   = shf(ref_rf[rm], sh);
    e.c   = 16'(e.a + e.b);
    if (wb) ref_rf[rd] = e.c;
    e.img = ref_rf;
    e.wr  = wb ? 1 : 0;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                       input logic oo, input logic wb, input logic [1:0] sh);
    wait_idle();
    bus.rn = rn; bus.rm = rm; bus.rd = rd;
    bus.one_op = oo; bus.wb_en = wb; bus.shift = sh;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    model(cyc, rn, rm, rd, oo, wb, sh);
    bus.start = 1'b0;
    scramble();
  endtask

  initial begin
    int k;
    int d0;
    int t;
    bus.start = 1'b0; bus.rn = '0; bus.rm = '0; bus.rd = '0;
    bus.one_op = 1'b0; bus.wb_en = 1'b0; bus.shift = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    ref_rf = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_readnum", bus.readnum, 0);
    chk("rst_writenum", bus.writenum, 0);
    chk("rst_a", bus.a_out, 0);
    chk("rst_b", bus.b_out, 0);
    chk("rst_data_in", bus.data_in, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) poke(3'(i), 16'(16'h1000 + i * 16'h0111));
    poke(3'd1, 16'h0003);
    poke(3'd2, 16'h0004);

    // Directed commands
    issue(3'd1, 3'd2, 3'd3, 1'b0, 1'b1, SH_NONE);   // R3 = 7
    issue(3'd7, 3'd2, 3'd5, 1'b1, 1'b1, SH_NONE);   // R5 = 4
    issue(3'd1, 3'd2, 3'd1, 1'b0, 1'b0, SH_NONE);   // no write-back

    // B shift codes
    poke(3'd2, 16'h8002);
    issue(3'd0, 3'd2, 3'd6, 1'b1, 1'b1, SH_LSL);
    issue(3'd0, 3'd2, 3'd6, 1'b1, 1'b1, SH_LSR);
    issue(3'd0, 3'd2, 3'd6, 1'b1, 1'b1, SH_ASR);
    issue(3'd0, 3'd2, 3'd6, 1'b1, 1'b1, SH_NONE);

    // Reset while in RD_B
    wait_idle();
    bus.rn = 3'd1; bus.rm = 3'd2; bus.rd = 3'd4;
    bus.one_op = 1'b0; bus.wb_en = 1'b1; bus.shift = SH_NONE;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rdb_rst_busy", bus.busy, 0);
    chk("rdb_rst_write", bus.write, 0);
    chk("rdb_rst_a", bus.a_out, 0);
    chk("rdb_rst_b", bus.b_out, 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset while in WB: write must drop and nothing may be committed
    wait_idle();
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wb_write_high", bus.write, 1);
    rst_n = 1'b0;
    #1;
    chk("wb_rst_write", bus.write, 0);
    @(posedge clk); #1;
    chk("wb_rst_rf", rf_mem, ref_rf);
    @(negedge clk) rst_n = 1'b1;

    // start held high for 10 cycles: two commands, 6 cycles apart
    wait_idle();
    bus.rn = 3'd3; bus.rm = 3'd3; bus.rd = 3'd3;
    bus.one_op = 1'b0; bus.wb_en = 1'b1; bus.shift = SH_NONE;
    bus.start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    k = cyc;
    model(k,     3'd3, 3'd3, 3'd3, 1'b0, 1'b1, SH_NONE);
    model(k + 6, 3'd3, 3'd3, 3'd3, 1'b0, 1'b1, SH_NONE);
    repeat (9) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("held_start_dones", 128'(done_cnt - d0), 128'd2);

    // Randomized commands with ignored starts while busy
    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        if (bus.busy === 1'b1) begin
          scramble();
          bus.start = 1'b1;
          @(negedge clk);
          bus.start = 1'b0;
        end
      end
    end

    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) flag("drain_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
